// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Shared md_op encodings for the multiply/divide unit, the
//               controller and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    localparam int unsigned c_XLEN = 32;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_mdu_arith.sv
`default_nettype none
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide datapath producing the pending
//               {hi_n, lo_n} pair and a divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_arith
    import mult_div_unit_pkg::*;
(
    input  logic [c_XLEN-1:0] a,
    input  logic [c_XLEN-1:0] b,
    input  md_op_e            md_op,
    output logic [c_XLEN-1:0] hi_n,
    output logic [c_XLEN-1:0] lo_n,
    output logic              div_zero
);

    logic signed [63:0]       w_prod_s;
    logic        [63:0]       w_prod_u;
    logic                     w_ovf;
    logic        [c_XLEN-1:0] w_udiv;
    logic        [c_XLEN-1:0] w_sdiv;
    logic signed [c_XLEN-1:0] w_sq;
    logic signed [c_XLEN-1:0] w_sr;
    logic        [c_XLEN-1:0] w_uq;
    logic        [c_XLEN-1:0] w_ur;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == '0);
    assign w_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Zero and overflow divisors are replaced by 1: zero results are discarded
    // upstream, and MIN/1 yields exactly the wrapped MIN/-1 answer with rem 0.
    assign w_udiv = div_zero ? 32'd1 : b;
    assign w_sdiv = (div_zero || w_ovf) ? 32'd1 : b;

    assign w_sq = $signed(a) / $signed(w_sdiv);
    assign w_sr = $signed(a) % $signed(w_sdiv);
    assign w_uq = a / w_udiv;
    assign w_ur = a % w_udiv;

    always_comb begin
        hi_n = '0;
        lo_n = '0;
        case (md_op)
            MD_MULT:  {hi_n, lo_n} = w_prod_s;
            MD_MULTU: {hi_n, lo_n} = w_prod_u;
            MD_DIV: begin
                hi_n = w_sr;
                lo_n = w_sq;
            end
            MD_DIVU: begin
                hi_n = w_ur;
                lo_n = w_uq;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : EX-stage MIPS multiply/divide unit with HI/LO registers,
//               fixed multi-cycle latency and exception cancellation.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        md_op,
    input  logic              cancel,
    input  logic [c_XLEN-1:0] a,
    input  logic [c_XLEN-1:0] b,
    output logic              busy,
    output logic [c_XLEN-1:0] hi,
    output logic [c_XLEN-1:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    md_op_e              w_op;
    logic                w_accept;
    logic [c_XLEN-1:0]   w_hi_n;
    logic [c_XLEN-1:0]   w_lo_n;
    logic                w_div_zero;

    logic                r_busy;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_XLEN-1:0]   r_hi;
    logic [c_XLEN-1:0]   r_lo;
    logic [c_XLEN-1:0]   r_hi_n;
    logic [c_XLEN-1:0]   r_lo_n;
    logic                r_pend_valid;

    assign w_op     = md_op_e'(md_op);
    assign w_accept = start && !cancel && !r_busy;

    mdu_arith u_arith (
        .a        (a),
        .b        (b),
        .md_op    (w_op),
        .hi_n     (w_hi_n),
        .lo_n     (w_lo_n),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_hi_n       <= '0;
            r_lo_n       <= '0;
            r_pend_valid <= 1'b0;
        end else if (r_busy) begin
            // Cancel is deliberately ignored here: the in-flight op is older.
            r_count <= r_count - c_CNT_ONE;
            if (r_count == c_CNT_ONE) begin
                r_busy       <= 1'b0;
                r_pend_valid <= 1'b0;
                if (r_pend_valid) begin
                    r_hi <= r_hi_n;
                    r_lo <= r_lo_n;
                end
            end
        end else if (w_accept) begin
            case (w_op)
                MD_MULT, MD_MULTU: begin
                    r_hi_n       <= w_hi_n;
                    r_lo_n       <= w_lo_n;
                    r_pend_valid <= 1'b1;
                    r_busy       <= 1'b1;
                    r_count      <= c_MULT_CNT;
                end
                MD_DIV, MD_DIVU: begin
                    // Divide by zero still occupies the unit but never commits.
                    r_hi_n       <= w_hi_n;
                    r_lo_n       <= w_lo_n;
                    r_pend_valid <= !w_div_zero;
                    r_busy       <= 1'b1;
                    r_count      <= c_DIV_CNT;
                end
                MD_MTHI: r_hi <= a;
                MD_MTLO: r_lo <= a;
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic
//               reference model of HI/LO and busy latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; returns just after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic vcancel);
        start  = 1'b1;
        md_op  = op;
        a      = va;
        b      = vb;
        cancel = vcancel;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = OP_NONE;
    endtask

    // Ticks until busy drops, bounded; returns cycles spent after the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Reference model: what HI/LO become once an op completes.
    task automatic model(input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, inout logic [31:0] rhi,
                         inout logic [31:0] rlo);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        sa = va;
        sb = vb;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                {rhi, rlo} = sp;
            end
            OP_MULTU: begin
                up = {32'd0, va} * {32'd0, vb};
                {rhi, rlo} = up;
            end
            OP_DIV: begin
                if (vb != 0) begin
                    if (va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) begin
                        rlo = 32'h8000_0000;
                        rhi = 32'd0;
                    end else begin
                        rlo = sa / sb;
                        rhi = sa % sb;
                    end
                end
            end
            OP_DIVU: begin
                if (vb != 0) begin
                    rlo = va / vb;
                    rhi = va % vb;
                end
            end
            OP_MTHI: rhi = va;
            OP_MTLO: rlo = va;
            default: ;
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
        end
    endtask

    task automatic test_mult_signed();
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        for (int i = 1; i < MULT_N; i++) begin
            checks++;
            if (busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL mult_hold c%0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                         i, busy, hi, lo, m_hi, m_lo);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b1 || hi !== m_hi) begin
            failures++;
            $display("FAIL mult_last_hold: busy=%b hi=%h, want busy=1 hi=%h", busy, hi, m_hi);
        end
        tick();
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFA;
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL mult_signed: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_multu();
        int n;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        checks++;
        if (n != MULT_N || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=fffffffe lo=00000001",
                     n, hi, lo, MULT_N);
        end
        m_hi = 32'hFFFF_FFFE;
        m_lo = 32'h0000_0001;
    endtask

    task automatic test_div_signed();
        int n;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(n);
        checks++;
        if (n != DIV_N || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_signed: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=ffffffff lo=fffffffd",
                     n, hi, lo, DIV_N);
        end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        checks++;
        if (n != DIV_N || lo !== 32'h8000_0000 || hi !== 32'd0) begin
            failures++;
            $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=0 lo=80000000",
                     n, hi, lo, DIV_N);
        end
        m_hi = 32'd0;
        m_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero();
        int n;
        issue(OP_MTHI, 32'h11, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h22, 32'd0, 1'b0);
        issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
        wait_done(n);
        checks++;
        if (n != DIV_N || hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=11 lo=22",
                     n, hi, lo, DIV_N);
        end
        m_hi = 32'h11;
        m_lo = 32'h22;
    endtask

    task automatic test_mtlo_cancel();
        issue(OP_MTLO, 32'h1234, 32'd0, 1'b1);
        checks++;
        if (lo !== m_lo || hi !== m_hi || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo_cancel: lo=%h hi=%h busy=%b, want lo=%h hi=%h busy=0",
                     lo, hi, busy, m_lo, m_hi);
        end
        issue(OP_MTLO, 32'h1234, 32'd0, 1'b0);
        m_lo = 32'h1234;
        checks++;
        if (lo !== 32'h1234 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: lo=%h busy=%b, want lo=00001234 busy=0", lo, busy);
        end
        issue(OP_MULT, 32'd9, 32'd9, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_cancel: busy=%b, want 0", busy);
        end
        issue(OP_NONE, 32'd5, 32'd5, 1'b0);
        checks++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL md_none: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                     busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_cancel_reset();
        issue(OP_MTHI, 32'hAA, 32'd0, 1'b0);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_while_busy: busy=%b, want 1", busy);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
        end
        for (int i = 0; i < DIV_N; i++) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(OP_MULTU, 32'd1000, 32'd3000, 1'b0);
        model(OP_MULTU, 32'd1000, 32'd3000, m_hi, m_lo);
        wait_done(n);
        issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);
        checks++;
        if (n != MULT_N || busy !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL b2b_first: cycles=%0d busy=%b hi=%h lo=%h, want cycles=%0d busy=1 hi=%h lo=%h",
                     n, busy, hi, lo, MULT_N, m_hi, m_lo);
        end
        model(OP_DIV, 32'hFFFF_FF9C, 32'd7, m_hi, m_lo);
        wait_done(n);
        checks++;
        if (n != DIV_N || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=%h lo=%h",
                     n, hi, lo, DIV_N, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        int          n;
        int          want_n;
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic        vc;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 6));
            va = $urandom;
            vb = $urandom;
            case ($urandom_range(0, 7))
                0: vb = 32'd0;
                1: vb = 32'($urandom_range(1, 15));
                2: va = 32'h8000_0000;
                3: vb = 32'hFFFF_FFFF;
                default: ;
            endcase
            vc = ($urandom_range(0, 4) == 0);
            issue(op, va, vb, vc);
            want_n = 0;
            if (!vc) begin
                model(op, va, vb, m_hi, m_lo);
                if (op == OP_MULT || op == OP_MULTU) want_n = MULT_N;
                if (op == OP_DIV || op == OP_DIVU) want_n = DIV_N;
            end
            wait_done(n);
            checks++;
            if (n != want_n || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cancel=%b: cycles=%0d hi=%h lo=%h, want cycles=%0d hi=%h lo=%h",
                         i, op, va, vb, vc, n, hi, lo, want_n, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        m_hi = '0;
        m_lo = '0;
        test_reset();
        test_mult_signed();
        test_multu();
        test_div_signed();
        test_div_zero();
        test_mtlo_cancel();
        test_cancel_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
